// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the BCD calculator: FSM states, status codes and
// command encodings, plus a constant power-of-ten helper used to size limits.
package bcd_calc_pkg;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_EXEC    = 3'd2,
      ST_SCAN    = 3'd3,
      ST_ERROR   = 3'd4
   } state_t;

   localparam logic [1:0] STAT_ERROR = 2'b00;
   localparam logic [1:0] STAT_BUSY  = 2'b01;
   localparam logic [1:0] STAT_READY = 2'b10;

   localparam logic [3:0] CMD_DIGIT_MAX = 4'd9;
   localparam logic [3:0] CMD_ADD       = 4'd10;
   localparam logic [3:0] CMD_SUB       = 4'd11;
   localparam logic [3:0] CMD_MUL       = 4'd12;
   localparam logic [3:0] CMD_DIV       = 4'd13;
   localparam logic [3:0] CMD_EQ        = 4'd14;
   localparam logic [3:0] CMD_BS        = 4'd15;

   // 10^n, evaluated at elaboration time for display limits.
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/bcd_calc_scan.sv
// bcd_scan: presents the value one decimal digit per cycle, least significant
// first, dividing the running remainder by ten each cycle. The first digit is
// taken straight from the value register so it is valid in the first scan cycle.
module bcd_scan #(
   parameter int DIGITS = 8,
   parameter int W      = 30,
   parameter int PW     = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_run,
   input  logic [W-1:0]  i_value,
   output logic [3:0]    o_data,
   output logic [PW-1:0] o_pos,
   output logic          o_last
);

   localparam logic [PW-1:0] C_LAST = PW'(DIGITS - 1);
   localparam logic [W-1:0]  C_TEN  = W'(10);

   logic [W-1:0]  r_rem;
   logic [PW-1:0] r_pos;
   logic [W-1:0]  w_cur;
   logic [W-1:0]  w_next;
   logic [3:0]    w_digit;

   assign w_cur   = (r_pos == '0) ? i_value : r_rem;
   assign w_next  = w_cur / C_TEN;
   assign w_digit = 4'(w_cur % C_TEN);
   assign o_data  = i_run ? w_digit : 4'd0;
   assign o_pos   = r_pos;
   assign o_last  = i_run && (r_pos == C_LAST);

   // Advance the digit index and remainder while scanning; park at 0 otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rem <= '0;
         r_pos <= '0;
      end else if (i_run) begin
         r_rem <= w_next;
         r_pos <= o_last ? '0 : r_pos + 1'b1;
      end else begin
         r_pos <= '0;
      end
   end

endmodule

// File: rtl/bcd_calc.sv
// bcd_calc: DIGITS-digit decimal calculator with scanned BCD display.
// Handshake: a command is taken on a rising clock edge where cmd_valid=1 and
// status=READY; cmd_valid in any other cycle has no effect.
// Optional feature: define BCD_CALC_DIV_EN to enable cmd 13 as integer division
// by repeated subtraction; without it cmd 13 is an error and no divider exists.
module bcd_calc
   import bcd_calc_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int W      = 30
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [3:0]                cmd,
   input  logic                      cmd_valid,
   output logic [1:0]                status,
   output logic [3:0]                data,
   output logic [$clog2(DIGITS)-1:0] pos,
   output logic [2:0]                state
);

   localparam int PW = $clog2(DIGITS);
   localparam logic [W-1:0] C_MAX  = W'(pow10(DIGITS) - 64'd1);
   localparam logic [W-1:0] C_FULL = W'(pow10(DIGITS - 1));
   localparam logic [W-1:0] C_TEN  = W'(10);
   localparam logic [W-1:0] C_ONE  = W'(1);

   state_t       r_state;
   state_t       r_ret;
   logic [1:0]   r_status;
   logic         r_boot;
   logic         r_first;
   logic [3:0]   r_op;
   logic [W-1:0] r_acc;
   logic [W-1:0] r_opa;
   logic [W-1:0] r_opb;
   logic [W-1:0] r_count;
   logic [W-1:0] r_res;
   logic [W-1:0] r_big;

   logic         w_accept;
   logic         w_is_digit;
   logic         w_op_ok;
   logic         w_scan_last;
   logic         w_a_ge_b;
   logic [W-1:0] w_acc_digit;
   logic [W-1:0] w_acc_bs;
   logic [W-1:0] w_min;
   logic [W-1:0] w_max;
   logic [W-1:0] w_diff;
   logic [W:0]   w_sum;
   logic [W:0]   w_mul_sum;

   assign w_accept    = cmd_valid && (r_status == STAT_READY);
   assign w_is_digit  = (cmd <= CMD_DIGIT_MAX);
   assign w_acc_digit = r_acc * C_TEN + W'(cmd);
   assign w_acc_bs    = r_acc / C_TEN;
   assign w_a_ge_b    = (r_opa >= r_opb);
   assign w_min       = w_a_ge_b ? r_opb : r_opa;
   assign w_max       = w_a_ge_b ? r_opa : r_opb;
   assign w_diff      = r_opa - r_opb;
   assign w_sum       = {1'b0, r_opa} + {1'b0, r_opb};
   assign w_mul_sum   = {1'b0, r_res} + {1'b0, r_big};

`ifdef BCD_CALC_DIV_EN
   logic [W-1:0] w_rem_dec;
   logic [W-1:0] w_q_inc;
   assign w_op_ok   = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL) || (cmd == CMD_DIV);
   assign w_rem_dec = r_count - r_opb;
   assign w_q_inc   = r_res + C_ONE;
`else
   assign w_op_ok   = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
`endif

   // Digit extraction for the display; scans whatever acc holds in SCAN.
   bcd_scan #(
      .DIGITS (DIGITS),
      .W      (W),
      .PW     (PW)
   ) u_scan (
      .clock   (clock),
      .reset   (reset),
      .i_run   (r_state == ST_SCAN),
      .i_value (r_acc),
      .o_data  (data),
      .o_pos   (pos),
      .o_last  (w_scan_last)
   );

   // Control FSM with registered status; every path into SCAN leaves the value
   // to be shown in acc, and r_ret records which entry state follows the scan.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_ENTER_A;
         r_ret    <= ST_ENTER_A;
         r_status <= STAT_BUSY;
         r_boot   <= 1'b1;
         r_first  <= 1'b0;
         r_op     <= '0;
         r_acc    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_count  <= '0;
         r_res    <= '0;
         r_big    <= '0;
      end else begin
         case (r_state)
            ST_ENTER_A, ST_ENTER_B: begin
               if (r_boot) begin
                  r_boot  <= 1'b0;
                  r_ret   <= ST_ENTER_A;
                  r_state <= ST_SCAN;
               end else if (w_accept) begin
                  if (w_is_digit) begin
                     if (r_acc < C_FULL) begin
                        r_acc    <= w_acc_digit;
                        r_ret    <= r_state;
                        r_state  <= ST_SCAN;
                        r_status <= STAT_BUSY;
                     end
                  end else if (cmd == CMD_BS) begin
                     r_acc    <= w_acc_bs;
                     r_ret    <= r_state;
                     r_state  <= ST_SCAN;
                     r_status <= STAT_BUSY;
                  end else if (cmd == CMD_EQ) begin
                     r_status <= STAT_BUSY;
                     if (r_state == ST_ENTER_B) begin
                        r_opb   <= r_acc;
                        r_first <= 1'b1;
                        r_state <= ST_EXEC;
                     end else begin
                        r_ret   <= ST_ENTER_A;
                        r_state <= ST_SCAN;
                     end
                  end else if (w_op_ok && (r_state == ST_ENTER_A)) begin
                     r_opa    <= r_acc;
                     r_acc    <= '0;
                     r_op     <= cmd;
                     r_ret    <= ST_ENTER_B;
                     r_state  <= ST_SCAN;
                     r_status <= STAT_BUSY;
                  end else begin
                     r_state  <= ST_ERROR;
                     r_status <= STAT_ERROR;
                  end
               end
            end
            ST_EXEC: begin
               r_first <= 1'b0;
               r_ret   <= ST_ENTER_A;
               case (r_op)
                  CMD_ADD: begin
                     if (w_sum > {1'b0, C_MAX}) begin
                        r_state  <= ST_ERROR;
                        r_status <= STAT_ERROR;
                     end else begin
                        r_acc   <= w_sum[W-1:0];
                        r_state <= ST_SCAN;
                     end
                  end
                  CMD_SUB: begin
                     if (!w_a_ge_b) begin
                        r_state  <= ST_ERROR;
                        r_status <= STAT_ERROR;
                     end else begin
                        r_acc   <= w_diff;
                        r_state <= ST_SCAN;
                     end
                  end
                  CMD_MUL: begin
                     if (r_first) begin
                        if (w_min == '0) begin
                           r_acc   <= '0;
                           r_state <= ST_SCAN;
                        end else begin
                           r_count <= w_min;
                           r_res   <= '0;
                           r_big   <= w_max;
                        end
                     end else if (w_mul_sum > {1'b0, C_MAX}) begin
                        r_state  <= ST_ERROR;
                        r_status <= STAT_ERROR;
                     end else if (r_count == C_ONE) begin
                        r_acc   <= w_mul_sum[W-1:0];
                        r_state <= ST_SCAN;
                     end else begin
                        r_res   <= w_mul_sum[W-1:0];
                        r_count <= r_count - C_ONE;
                     end
                  end
`ifdef BCD_CALC_DIV_EN
                  CMD_DIV: begin
                     if (r_first) begin
                        if (r_opb == '0) begin
                           r_state  <= ST_ERROR;
                           r_status <= STAT_ERROR;
                        end else if (!w_a_ge_b) begin
                           r_acc   <= '0;
                           r_state <= ST_SCAN;
                        end else begin
                           r_count <= r_opa;
                           r_res   <= '0;
                        end
                     end else if (w_rem_dec < r_opb) begin
                        r_acc   <= w_q_inc;
                        r_state <= ST_SCAN;
                     end else begin
                        r_count <= w_rem_dec;
                        r_res   <= w_q_inc;
                     end
                  end
`endif
                  default: begin
                     r_state  <= ST_ERROR;
                     r_status <= STAT_ERROR;
                  end
               endcase
            end
            ST_SCAN: begin
               if (w_scan_last) begin
                  r_state  <= r_ret;
                  r_status <= STAT_READY;
               end
            end
            ST_ERROR: begin
               r_status <= STAT_ERROR;
            end
            default: begin
               r_state  <= ST_ERROR;
               r_status <= STAT_ERROR;
            end
         endcase
      end
   end

   assign status = r_status;
   assign state  = r_state;

endmodule

// File: tb/tb_bcd_calc.sv
// Bench for bcd_calc (DIGITS=8): directed command sequences; each scan is
// expected as eight digits pushed to exp_q and checked by a separate monitor.
module tb_bcd_calc;

   localparam logic [1:0] S_ERR   = 2'b00;
   localparam logic [1:0] S_BUSY  = 2'b01;
   localparam logic [1:0] S_READY = 2'b10;
   localparam logic [2:0] Q_A     = 3'd0;
   localparam logic [2:0] Q_EXEC  = 3'd2;
   localparam logic [2:0] Q_SCAN  = 3'd3;
   localparam logic [2:0] Q_ERR   = 3'd4;

   logic       clock;
   logic       reset;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [1:0] status;
   logic [3:0] data;
   logic [2:0] pos;
   logic [2:0] state;

   logic [3:0] exp_q[$];
   logic [2:0] mon_pos;
   int n_checks;
   int n_errors;

   bcd_calc #(.DIGITS(8), .W(30)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .status    (status),
      .data      (data),
      .pos       (pos),
      .state     (state)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard monitor: every SCAN cycle pops one expected digit
   always @(negedge clock) begin
      if (reset) begin
         mon_pos = 3'd0;
      end else if (state == Q_SCAN) begin
         chk("scan_status", status, S_BUSY);
         chk("scan_pos", pos, mon_pos);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scan_extra: got digit %0d at pos %0d, expected no scan", data, pos);
         end else begin
            chk("scan_digit", data, exp_q.pop_front());
         end
         mon_pos = mon_pos + 3'd1;
      end else begin
         mon_pos = 3'd0;
      end
   end

   task automatic push_val(input longint unsigned v);
      longint unsigned t;
      t = v;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(4'(t % 10));
         t = t / 10;
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (status == S_READY) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ready_timeout", status, S_READY);
   endtask

   // driver: one command, issued only once READY is seen
   task automatic send(input logic [3:0] c);
      bit ok;
      wait_ready(ok);
      if (ok) begin
         cmd       = c;
         cmd_valid = 1'b1;
         @(posedge clock);
         #1 cmd_valid = 1'b0;
      end
   endtask

   task automatic step(input logic [3:0] c, input longint unsigned v);
      push_val(v);
      send(c);
   endtask

   task automatic exec_wait(output int lat);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (state != Q_EXEC) break;
         lat++;
      end
   endtask

   task automatic step_eq(input longint unsigned v, input int exp_lat);
      int lat;
      push_val(v);
      send(4'd14);
      exec_wait(lat);
      chk("exec_latency", lat, exp_lat);
   endtask

   task automatic expect_error(input string name, input bit via_exec);
      int lat;
      if (via_exec) exec_wait(lat);
      else @(negedge clock);
      chk({name, "_state"}, state, Q_ERR);
      chk({name, "_status"}, status, S_ERR);
      chk({name, "_data"}, data, 0);
   endtask

   task automatic do_reset();
      int lat;
      @(posedge clock);
      #1 reset = 1'b1;
      exp_q.delete();
      cmd_valid = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_status", status, S_BUSY);
      chk("rst_data", data, 0);
      chk("rst_pos", pos, 0);
      chk("rst_state", state, Q_A);
      push_val(0);
      @(negedge clock);
      reset = 1'b0;
      lat = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clock);
         if (status == S_READY) begin
            lat = i;
            break;
         end
      end
      chk("rst_ready_latency", lat, 9);
   endtask

   initial begin
      bit ok;
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b0;
      cmd       = 4'd0;
      cmd_valid = 1'b0;

      // 12 + 34 = 46
      do_reset();
      step(4'd1, 1);
      step(4'd2, 12);
      step(4'd10, 0);
      step(4'd3, 3);
      step(4'd4, 34);
      step_eq(46, 1);
      wait_ready(ok);
      chk("after_add_state", state, Q_A);

      // 9 * 7 = 63, then chained + 1 = 64
      do_reset();
      step(4'd9, 9);
      step(4'd12, 0);
      step(4'd7, 7);
      step_eq(63, 8);
      step(4'd10, 0);
      step(4'd1, 1);
      step_eq(64, 1);

      // 0 * 5 = 0 in one cycle
      do_reset();
      step(4'd0, 0);
      step(4'd12, 0);
      step(4'd5, 5);
      step_eq(0, 1);

      // 3 - 5 underflows; error holds and ignores commands
      do_reset();
      step(4'd3, 3);
      step(4'd11, 0);
      step(4'd5, 5);
      send(4'd14);
      expect_error("sub_neg", 1'b1);
      repeat (5) @(negedge clock);
      cmd = 4'd1;
      cmd_valid = 1'b1;
      repeat (2) @(negedge clock);
      cmd_valid = 1'b0;
      chk("err_hold_state", state, Q_ERR);
      chk("err_hold_status", status, S_ERR);

      // full entry: ninth digit ignored, then overflow on +1
      do_reset();
      step(4'd9, 9);
      step(4'd9, 99);
      step(4'd9, 999);
      step(4'd9, 9999);
      step(4'd9, 99999);
      step(4'd9, 999999);
      step(4'd9, 9999999);
      step(4'd9, 99999999);
      send(4'd9);
      @(negedge clock);
      chk("full_ignore_status", status, S_READY);
      step(4'd10, 0);
      step(4'd1, 1);
      send(4'd14);
      expect_error("add_ovf", 1'b1);

      // backspace: 1,5,BS -> 1; equals in ENTER_A rescans acc
      do_reset();
      step(4'd1, 1);
      step(4'd5, 15);
      step(4'd15, 1);
      step(4'd14, 1);

      // backspace at zero stays zero
      do_reset();
      step(4'd15, 0);

      // operator in ENTER_B
      do_reset();
      step(4'd1, 1);
      step(4'd10, 0);
      send(4'd10);
      expect_error("op_in_b", 1'b0);

      // cmd_valid during SCAN is ignored; reset mid-scan aborts cleanly
      do_reset();
      step(4'd1, 1);
      @(negedge clock);
      cmd = 4'd5;
      cmd_valid = 1'b1;
      repeat (3) @(negedge clock);
      cmd_valid = 1'b0;
      step(4'd14, 1);
      step(4'd7, 17);
      @(negedge clock);
      do_reset();
      step(4'd14, 0);

      // cmd 13
      do_reset();
      step(4'd8, 8);
`ifdef BCD_CALC_DIV_EN
      step(4'd13, 0);
      step(4'd3, 3);
      step_eq(2, 3);
      do_reset();
      step(4'd5, 5);
      step(4'd13, 0);
      step(4'd0, 0);
      send(4'd14);
      expect_error("div_zero", 1'b1);
`else
      send(4'd13);
      expect_error("div_off", 1'b0);
`endif

      repeat (12) @(negedge clock);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
